// File: rtl/dmem_pkg.sv
// Shared types, defaults and helpers for the data-memory responder.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (see dmem_responder).
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int DMEM_DATA_W  = 32;
    localparam int DMEM_ADDR_W  = 32;
    localparam int DMEM_DEPTH   = 1024;
    localparam int DMEM_LATENCY = 2;

    // Ceiling log2, usable in constant expressions (n >= 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, registered read that holds
// its value when no read is issued. No reset on storage or read register.
import dmem_pkg::*;

module dmem_array #(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int IDX_W  = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[idx] <= wdata;
        end
    end

    // Registered read port; holds between reads.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[idx];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Req/Ack data-memory responder with programmable wait states.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned accesses with Err.
import dmem_pkg::*;

module dmem_responder #(
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DEPTH   = DMEM_DEPTH,
    parameter int LATENCY = DMEM_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int IDX_W = clog2(DEPTH);
    localparam int CNT_W = clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    dmem_state_t       state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic              we_r, mis_r;
    logic [IDX_W-1:0]  idx_r;
    logic [DATA_W-1:0] wdata_r;
    logic              busy_r, ack_r, err_r, rd_valid_r;

    logic              lat_en_s, access_s, req_mis_s;
    logic              acc_we_s, acc_mis_s;
    logic [IDX_W-1:0]  acc_idx_s;
    logic [DATA_W-1:0] acc_wdata_s;
    logic              arr_we_s, arr_re_s;
    logic [DATA_W-1:0] arr_q_s;
    logic              unused_addr_s;

`ifdef DMEM_ALIGN_CHECK_EN
    assign req_mis_s = (addr[1:0] != 2'b00);
`else
    assign req_mis_s = 1'b0;
`endif
    assign unused_addr_s = ^addr;

    // With LATENCY = 1 the access happens at the accept edge, so it must use the live request.
    always_comb begin
        if (state_r == IDLE) begin
            acc_we_s    = we;
            acc_mis_s   = req_mis_s;
            acc_idx_s   = addr[IDX_W+1:2];
            acc_wdata_s = wdata;
        end else begin
            acc_we_s    = we_r;
            acc_mis_s   = mis_r;
            acc_idx_s   = idx_r;
            acc_wdata_s = wdata_r;
        end
    end

    // Next-state, counter and access-strobe decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        lat_en_s    = 1'b0;
        access_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req) begin
                    lat_en_s  = 1'b1;
                    cnt_nxt_s = CNT_LOAD;
                    if (LATENCY == 1) begin
                        access_s    = 1'b1;
                        state_nxt_s = RESP;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                cnt_nxt_s = cnt_r - CNT_ONE;
                if (cnt_r <= CNT_ONE) begin
                    access_s    = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Gated by reset so an aborted request can never touch the array.
    assign arr_we_s = access_s & acc_we_s & ~acc_mis_s & ~reset;
    assign arr_re_s = access_s & ~acc_we_s & ~acc_mis_s & ~reset;

    // FSM state and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Request latches captured at accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_r    <= 1'b0;
            mis_r   <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
        end else if (lat_en_s) begin
            we_r    <= we;
            mis_r   <= req_mis_s;
            idx_r   <= addr[IDX_W+1:2];
            wdata_r <= wdata;
        end
    end

    // Registered handshake outputs; rd_valid_r masks the unreset array read register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r     <= 1'b0;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != IDLE);
            ack_r  <= access_s;
            err_r  <= access_s & acc_mis_s;
            if (access_s && acc_mis_s) begin
                rd_valid_r <= 1'b0;
            end else if (access_s && !acc_we_s) begin
                rd_valid_r <= 1'b1;
            end
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we_s),
        .re    (arr_re_s),
        .idx   (acc_idx_s),
        .wdata (acc_wdata_s),
        .rdata (arr_q_s)
    );

    assign busy  = busy_r;
    assign ack   = ack_r;
    assign err   = err_r;
    assign rdata = rd_valid_r ? arr_q_s : {DATA_W{1'b0}};

endmodule
